// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter between NUM_REQ byte-stream
//            requesters. Round-robin arbitration at packet granularity: a
//            granted requester keeps the transmitter until it sends a byte
//            flagged last (or its lock times out while it stalls).
//            The TX byte is held stable for the whole frame because the
//            transmitter samples data_in during its DATA bits.
// Ports    : clk, rst           clock, synchronous active-high reset
//            req_data_i         byte of requester i at [8*i+7:8*i]
//            req_valid_i        requester i has a byte
//            req_last_i         byte of requester i ends its packet
//            req_ready_o        byte of requester i consumed at this edge
//            tx_data_o          to transmitter data_in
//            tx_valid_o         to transmitter data_in_valid
//            tx_ready_i         from transmitter data_in_ready
//            grant_id_o         index of last accepted requester
//            locked_o           mid-packet lock held by grant_id_o
//            lock_timeout_o     one-cycle pulse on forced lock release
//            busy_o             sequencer not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter  int NUM_REQ      = 2,
    parameter  int LOCK_TIMEOUT = 1_000_000,
    localparam int ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic [ID_WIDTH-1:0]    grant_id_o,
    output logic                   locked_o,
    output logic                   lock_timeout_o,
    output logic                   busy_o
);

    localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_LOW  = 2'd2,
        S_WAIT_HIGH = 2'd3
    } state_t;

    state_t               state_q;
    logic [7:0]           tx_data_q;
    logic                 tx_valid_q;
    logic [ID_WIDTH-1:0]  grant_q;
    logic [ID_WIDTH-1:0]  rr_q;
    logic                 locked_q;
    logic                 lock_to_q;
    logic [TW-1:0]        timer_q;

    logic                 sel_found;
    logic [ID_WIDTH-1:0]  sel_id;
    logic [7:0]           sel_data;
    logic                 sel_last;
    logic                 accept;

    // Candidate selection. While locked only the lock holder is eligible;
    // otherwise scan upward from the requester after the last packet owner.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_id    = grant_q;
        if (locked_q) begin
            sel_found = req_valid_i[grant_q];
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!sel_found && req_valid_i[idx]) begin
                    sel_found = 1'b1;
                    sel_id    = ID_WIDTH'(idx);
                end
            end
        end
    end

    assign sel_data = req_data_i[8*int'(sel_id) +: 8];
    assign sel_last = req_last_i[sel_id];
    assign accept   = (state_q == S_IDLE) && sel_found;

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[sel_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            grant_q    <= '0;
            rr_q       <= ID_WIDTH'(NUM_REQ - 1);
            locked_q   <= 1'b0;
            lock_to_q  <= 1'b0;
            timer_q    <= '0;
        end else begin
            lock_to_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        // An accept always wins over a simultaneous timeout.
                        tx_data_q  <= sel_data;
                        tx_valid_q <= 1'b1;
                        grant_q    <= sel_id;
                        timer_q    <= '0;
                        state_q    <= S_ISSUE;
                        if (sel_last) begin
                            locked_q <= 1'b0;
                            rr_q     <= sel_id;
                        end else begin
                            locked_q <= 1'b1;
                        end
                    end else if (locked_q && (LOCK_TIMEOUT != 0)) begin
                        // Locked holder is stalled here (no accept happened).
                        if (timer_q == TIMER_LAST) begin
                            locked_q  <= 1'b0;
                            rr_q      <= grant_q;
                            lock_to_q <= 1'b1;
                            timer_q   <= '0;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    if (tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_WAIT_LOW;
                    end
                end
                S_WAIT_LOW: begin
                    // Skip the transmitter's post-accept ready-high cycle.
                    if (!tx_ready_i) begin
                        state_q <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (tx_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_data_o      = tx_data_q;
    assign tx_valid_o     = tx_valid_q;
    assign grant_id_o     = grant_q;
    assign locked_o       = locked_q;
    assign lock_timeout_o = lock_to_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed bench for uart_tx_arbiter with a behavioural UART
//            transmitter (ready stays high one cycle after accept, samples
//            data_in during DATA bits) and a mid-bit serial receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 2;
    localparam int LOCK_TO = 20;
    localparam int BITC    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req_data  = '0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_last  = '0;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [0:0]  grant_id;
    logic        locked;
    logic        lock_timeout;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .LOCK_TIMEOUT(LOCK_TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_data_i     (req_data),
        .req_valid_i    (req_valid),
        .req_last_i     (req_last),
        .req_ready_o    (req_ready),
        .tx_data_o      (tx_data),
        .tx_valid_o     (tx_valid),
        .tx_ready_i     (tx_ready),
        .grant_id_o     (grant_id),
        .locked_o       (locked),
        .lock_timeout_o (lock_timeout),
        .busy_o         (busy)
    );

    // ---------------- transmitter model + receiver ----------------
    typedef enum logic [2:0] {M_IDLE, M_TAIL, M_START, M_DATA, M_STOP} mst_t;
    mst_t       m_st = M_IDLE;
    int         m_cnt = 0;
    int         m_bit = 0;
    logic [7:0] m_sh  = '0;
    logic [7:0] m_acc = '0;
    logic       ser;
    int         n_starts = 0;
    int         tail_viol = 0;
    int         unstable = 0;
    logic [7:0] rxq[$];

    assign tx_ready = (m_st == M_IDLE) || (m_st == M_TAIL);

    always_comb begin
        ser = 1'b1;
        if (m_st == M_START) ser = 1'b0;
        else if (m_st == M_DATA) ser = tx_data[m_bit[2:0]];
    end

    always @(posedge clk) begin
        if (rst) begin
            m_st  <= M_IDLE;
            m_cnt <= 0;
            m_bit <= 0;
        end else begin
            if (m_st != M_IDLE && tx_data !== m_acc) unstable <= unstable + 1;
            case (m_st)
                M_IDLE: if (tx_valid) begin m_acc <= tx_data; m_st <= M_TAIL; end
                M_TAIL: begin
                    if (tx_valid) tail_viol <= tail_viol + 1;
                    m_st     <= M_START;
                    m_cnt    <= 0;
                    n_starts <= n_starts + 1;
                end
                M_START: if (m_cnt == BITC-1) begin m_cnt <= 0; m_bit <= 0; m_st <= M_DATA; end
                         else m_cnt <= m_cnt + 1;
                M_DATA: begin
                    if (m_cnt == BITC/2) m_sh[m_bit[2:0]] <= ser;
                    if (m_cnt == BITC-1) begin
                        m_cnt <= 0;
                        if (m_bit == 7) m_st <= M_STOP;
                        else m_bit <= m_bit + 1;
                    end else m_cnt <= m_cnt + 1;
                end
                M_STOP: if (m_cnt == BITC-1) begin
                            m_cnt <= 0;
                            m_st  <= M_IDLE;
                            rxq.push_back(m_sh);
                        end else m_cnt <= m_cnt + 1;
                default: m_st <= M_IDLE;
            endcase
        end
    end

    // ---------------- bench state ----------------
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [8:0] fq0[$];
    logic [8:0] fq1[$];
    int         acc_id[$];
    logic [7:0] acc_data[$];
    logic       acc_lock[$];
    int         acc_total = 0;
    int         cyc = 0;
    int         to_cnt = 0;
    int         to_cyc = 0;
    int         idle_cyc = 0;
    logic       busy_prev = 1'b0;
    logic [1:0] prev_taken = '0;
    int         multi_rdy = 0;
    int         rdy_outside = 0;
    int         lat_viol = 0;
    int         rx_base = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qid(input int k);
        return (k < acc_id.size()) ? 32'(acc_id[k]) : 32'hFFFF;
    endfunction

    function automatic logic [31:0] qlock(input int k);
        return (k < acc_lock.size()) ? 32'(acc_lock[k]) : 32'hFFFF;
    endfunction

    function automatic logic [31:0] qrx(input int k);
        return (rx_base + k < rxq.size()) ? 32'(rxq[rx_base + k]) : 32'hFFFF;
    endfunction

    task automatic drive();
        req_valid[0] = (fq0.size() > 0);
        req_valid[1] = (fq1.size() > 0);
        if (fq0.size() > 0) {req_last[0], req_data[7:0]}  = fq0[0];
        if (fq1.size() > 0) {req_last[1], req_data[15:8]} = fq1[0];
    endtask

    // One clock: observe at the falling edge, update requesters after the rising edge.
    task automatic step();
        logic [1:0] taken;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                acc_id.push_back(i);
                acc_data.push_back(req_data[8*i +: 8]);
                acc_lock.push_back(locked);
                acc_total++;
            end
        end
        if (req_ready == 2'b11) multi_rdy++;
        if (req_ready != 2'b00 && busy) rdy_outside++;
        if (prev_taken != 2'b00 && !tx_valid) lat_viol++;
        if (lock_timeout) begin to_cnt++; to_cyc = cyc; end
        if (busy_prev && !busy && to_cnt == 0) idle_cyc = cyc;
        busy_prev  = busy;
        taken      = req_ready;
        prev_taken = taken;
        @(posedge clk);
        #1;
        if (taken[0]) void'(fq0.pop_front());
        if (taken[1]) void'(fq1.pop_front());
        drive();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = (fq0.size() == 0) && (fq1.size() == 0) && !busy && (m_st == M_IDLE) && !tx_valid;
        end
        check({tag, " completes in budget"}, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fq0.delete();
        fq1.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        acc_id.delete();
        acc_data.delete();
        acc_lock.delete();
        to_cnt     = 0;
        busy_prev  = 1'b0;
        prev_taken = '0;
        rx_base    = rxq.size();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        // ---- reset values ----
        do_reset();
        check("rst tx_valid",     32'(tx_valid),     32'd0);
        check("rst tx_data",      32'(tx_data),      32'h00);
        check("rst req_ready",    32'(req_ready),    32'd0);
        check("rst grant_id",     32'(grant_id),     32'd0);
        check("rst locked",       32'(locked),       32'd0);
        check("rst lock_timeout", 32'(lock_timeout), 32'd0);
        check("rst busy",         32'(busy),         32'd0);
        check("rst serial idle",  32'(ser),          32'd1);

        // ---- single byte ----
        fq0.push_back({1'b1, 8'h55});
        drive();
        wait_done("single", 400);
        check("single accepts",  32'(acc_id.size()), 32'd1);
        check("single acc id",   qid(0),             32'd0);
        check("single rx count", 32'(rxq.size() - rx_base), 32'd1);
        check("single rx byte",  qrx(0),             32'h55);
        check("single grant_id", 32'(grant_id),      32'd0);
        check("single locked",   32'(locked),        32'd0);

        // ---- round-robin ----
        do_reset();
        fq0.push_back({1'b1, 8'hA0}); fq0.push_back({1'b1, 8'hA1});
        fq1.push_back({1'b1, 8'hB0}); fq1.push_back({1'b1, 8'hB1});
        drive();
        wait_done("rr", 1000);
        check("rr grant 0", qid(0), 32'd0);
        check("rr grant 1", qid(1), 32'd1);
        check("rr grant 2", qid(2), 32'd0);
        check("rr grant 3", qid(3), 32'd1);
        check("rr rx 0", qrx(0), 32'hA0);
        check("rr rx 1", qrx(1), 32'hB0);
        check("rr rx 2", qrx(2), 32'hA1);
        check("rr rx 3", qrx(3), 32'hB1);

        // ---- packet lock ----
        do_reset();
        fq0.push_back({1'b0, 8'h48}); fq0.push_back({1'b0, 8'h49}); fq0.push_back({1'b1, 8'h0A});
        fq1.push_back({1'b1, 8'h77});
        drive();
        wait_done("lock", 1000);
        check("lock id 0", qid(0), 32'd0);
        check("lock id 1", qid(1), 32'd0);
        check("lock id 2", qid(2), 32'd0);
        check("lock id 3", qid(3), 32'd1);
        check("lock held before byte 2", qlock(1), 32'd1);
        check("lock held before byte 3", qlock(2), 32'd1);
        check("lock free before req1",   qlock(3), 32'd0);
        check("lock rx 0", qrx(0), 32'h48);
        check("lock rx 1", qrx(1), 32'h49);
        check("lock rx 2", qrx(2), 32'h0A);
        check("lock rx 3", qrx(3), 32'h77);

        // ---- lock timeout ----
        do_reset();
        fq0.push_back({1'b0, 8'h11});
        fq1.push_back({1'b1, 8'h22});
        drive();
        wait_done("timeout", 1000);
        check("timeout pulses",     32'(to_cnt),           32'd1);
        check("timeout delay",      32'(to_cyc - idle_cyc), 32'd20);
        check("timeout first id",   qid(0),                32'd0);
        check("timeout next id",    qid(1),                32'd1);
        check("timeout rx 1",       qrx(1),                32'h22);
        check("timeout locked end", 32'(locked),           32'd0);

        // ---- reset mid-DATA ----
        do_reset();
        fq0.push_back({1'b0, 8'h3C});
        drive();
        n = 0;
        while (!(m_st == M_DATA && m_bit == 3) && n < 400) begin
            step();
            n++;
        end
        check("rstmid reached bit 3", 32'(m_st == M_DATA && m_bit == 3), 32'd1);
        check("rstmid locked before", 32'(locked), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmid tx_valid",  32'(tx_valid),  32'd0);
        check("rstmid tx_data",   32'(tx_data),   32'h00);
        check("rstmid busy",      32'(busy),      32'd0);
        check("rstmid locked",    32'(locked),    32'd0);
        check("rstmid grant_id",  32'(grant_id),  32'd0);
        check("rstmid req_ready", 32'(req_ready), 32'd0);
        check("rstmid serial",    32'(ser),       32'd1);
        prev_taken = '0;
        busy_prev  = 1'b0;
        rx_base    = rxq.size();
        fq0.push_back({1'b1, 8'hC3});
        drive();
        wait_done("rstmid fresh", 400);
        check("rstmid fresh rx count", 32'(rxq.size() - rx_base), 32'd1);
        check("rstmid fresh rx",       qrx(0),                    32'hC3);

        // ---- global invariants ----
        check("ready-tail tx_valid", 32'(tail_viol),   32'd0);
        check("tx_data stable",      32'(unstable),    32'd0);
        check("single ready bit",    32'(multi_rdy),   32'd0);
        check("ready only in idle",  32'(rdy_outside), 32'd0);
        check("accept latency",      32'(lat_viol),    32'd0);
        check("starts equal accepts", 32'(n_starts),   32'(acc_total));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_transmitter between NUM_REQ byte-stream requesters, e.g. CPU MMIO TX path and a hardware debug/trace printer.
- Round-robin arbitration at packet granularity: once a requester is granted, it keeps the transmitter until it sends a byte flagged last. Bytes from different requesters never interleave inside a packet.
- Sequences the transmitter's ready/valid interface and holds the TX byte stable for the whole frame, because the transmitter samples data_in during its DATA bits rather than latching it at accept.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- LOCK_TIMEOUT, 1_000_000: idle cycles a locked requester may stall mid-packet before the lock is forcibly released. 0 disables the timeout.
- ID_WIDTH, $clog2(NUM_REQ) (min 1): grant index width. Localparam.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_data  in  8*NUM_REQ  byte from requester i at [8*i+7:8*i]
- req_valid  in  NUM_REQ  requester i has a byte
- req_last  in  NUM_REQ  byte i ends its packet; releases the lock
- req_ready  out  NUM_REQ  byte i consumed at this edge
- tx_data  out  8  to transmitter data_in
- tx_valid  out  1  to transmitter data_in_valid
- tx_ready  in  1  from transmitter data_in_ready
- grant_id  out  ID_WIDTH  index of last accepted requester
- locked  out  1  mid-packet lock held by grant_id
- lock_timeout  out  1  one-cycle pulse when a lock is force-released
- busy  out  1  state != IDLE

Behaviour:
- Reset values: tx_valid=0, tx_data=0, req_ready=0, grant_id=0, locked=0, lock_timeout=0, busy=0. State=IDLE. rr_ptr=NUM_REQ-1, so requester 0 has first priority. Lock timer=0.
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE, selection:
  - Unlocked: pick the first i with req_valid[i], scanning rr_ptr+1, rr_ptr+2, ... with modulo-NUM_REQ wrap.
  - Locked: only grant_id is eligible; all other valids are ignored.
- IDLE, accept:
  - req_ready[sel] is high combinationally in the same cycle, only if req_valid[sel]=1. At most one req_ready bit is high in any cycle.
  - At that edge: latch req_data into tx_data; grant_id<=sel; go to ISSUE.
  - If req_last=0: locked<=1.
  - If req_last=1: locked<=0 and rr_ptr<=sel.
- ISSUE: tx_valid=1. On the edge with tx_ready=1: tx_valid<=0, go to WAIT_LOW.
- WAIT_LOW: wait for tx_ready=0, then go to WAIT_HIGH. The transmitter keeps ready high for one cycle after accepting; that cycle must not count as a new accept.
- WAIT_HIGH: wait for tx_ready=1 (stop bit complete), then go to IDLE.
- tx_data holds constant from latch until return to IDLE.
- Latency: byte accepted at edge T → tx_valid=1 from T+1. Back-to-back bytes have one IDLE cycle between the end of frame and the next accept. req_ready is never high outside IDLE.
- Lock timeout:
  - The timer counts cycles in IDLE while locked=1 and req_valid[grant_id]=0. It clears on any accept.
  - When it reaches LOCK_TIMEOUT: locked<=0, rr_ptr<=grant_id, lock_timeout pulses for 1 cycle, timer clears. Arbitration resumes the next cycle.
- Simultaneous events:
  - A valid dropped by a requester before ready is fine; no byte is consumed.
  - req_valid of the locked requester and the timeout expiry in the same cycle: the accept wins and the timer clears.
- Reset mid-frame: all state returns to reset values at once. tx_valid drops; the transmitter is reset by the same rst. Partial packets are abandoned and the lock is cleared.
- NUM_REQ=1: degenerates to a frame sequencer; the lock is irrelevant but still reported.

Test Plan:
- Single byte: req0 sends 0x55 with last=1.
  - req_ready[0] pulses once.
  - tx_valid high exactly until the transmitter accepts.
  - tx_data=0x55 stable until the frame ends.
  - Serial line shows 0x55 LSB-first.
  - grant_id=0, locked=0 afterwards.
- Round-robin: both requesters continuously valid, every byte last=1.
  - Grant order is 0,1,0,1.
  - Serial bytes alternate req0/req1 data (0xA0,0xB0,0xA1,0xB1).
- Packet lock: req0 sends a 3-byte packet 0x48,0x49,0x0A (last on 0x0A) while req1 is valid throughout.
  - All three req0 bytes go out before any req1 byte.
  - locked=1 between bytes.
  - req_ready[1] stays 0 until the release.
- Timeout: LOCK_TIMEOUT=20, req0 sends one byte with last=0, then goes idle; req1 is valid.
  - lock_timeout pulses 20 IDLE cycles after the frame ends.
  - The next accepted byte is from req1.
- Ready-tail guard: check that tx_valid is 0 during the transmitter's post-accept ready-high cycle. Exactly one frame per accepted byte (count START edges = accepts).
- Reset mid-DATA: assert rst during bit 3.
  - Outputs return to reset values the next cycle.
  - The serial line goes idle high.
  - A fresh byte afterwards transmits correctly.
